// File: rtl/alt_vipvfr131_flow_ctrl_pkg.sv
// rtl/alt_vipvfr131_flow_ctrl_pkg.sv - shared constants and helpers for the buffered flow-control wrapper
// Contents: reset frame geometry defaults, a clog2 function, and the output FIFO entry width helper.
package alt_vipvfr131_flow_ctrl_pkg;

    localparam int WIDTH_INIT_DEF  = 640;
    localparam int HEIGHT_INIT_DEF = 480;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Each FIFO entry carries the video beat plus its end-of-video marker.
    function automatic int fifo_entry_width(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/alt_vipvfr131_common_flow_control_buffered_if.sv
// rtl/alt_vipvfr131_common_flow_control_buffered_if.sv - decoder/algorithm/encoder signal bundle
// Ports: all decoder-side, algorithm-side and encoder-side signals of the wrapper.
// slave modport = wrapper view, master modport = surrounding datapath (or bench) view.
interface alt_vipvfr131_common_flow_control_buffered_if #(
    parameter int DW = 24
);
    // decoder side
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] din_data;
    logic [15:0]   decoder_width;
    logic [15:0]   decoder_height;
    logic [3:0]    decoder_interlaced;
    logic          decoder_end_of_video;
    logic          decoder_is_video;
    logic          decoder_vip_ctrl_valid;
    // to algorithm
    logic [DW-1:0] data_in;
    logic [15:0]   width_in;
    logic [15:0]   height_in;
    logic [3:0]    interlaced_in;
    logic          end_of_video_in;
    logic          vip_ctrl_valid_in;
    // from algorithm
    logic [DW-1:0] data_out;
    logic [15:0]   width_out;
    logic [15:0]   height_out;
    logic [3:0]    interlaced_out;
    logic          vip_ctrl_valid_out;
    logic          end_of_video_out;
    // encoder side
    logic          dout_ready;
    logic          dout_valid;
    logic [DW-1:0] dout_data;
    logic          encoder_end_of_video;
    logic [15:0]   encoder_width;
    logic [15:0]   encoder_height;
    logic [3:0]    encoder_interlaced;
    logic          encoder_vip_ctrl_send;
    logic          encoder_vip_ctrl_busy;
    // algorithm flow control
    logic          read;
    logic          write;
    logic          stall_in;
    logic          stall_out;
    logic          overflow_err;

    modport slave (
        input  din_valid, din_data, decoder_width, decoder_height, decoder_interlaced,
               decoder_end_of_video, decoder_is_video, decoder_vip_ctrl_valid,
               data_out, width_out, height_out, interlaced_out, vip_ctrl_valid_out,
               end_of_video_out, dout_ready, encoder_vip_ctrl_busy, read, write,
        output din_ready, data_in, width_in, height_in, interlaced_in, end_of_video_in,
               vip_ctrl_valid_in, dout_valid, dout_data, encoder_end_of_video,
               encoder_width, encoder_height, encoder_interlaced, encoder_vip_ctrl_send,
               stall_in, stall_out, overflow_err
    );

    modport master (
        output din_valid, din_data, decoder_width, decoder_height, decoder_interlaced,
               decoder_end_of_video, decoder_is_video, decoder_vip_ctrl_valid,
               data_out, width_out, height_out, interlaced_out, vip_ctrl_valid_out,
               end_of_video_out, dout_ready, encoder_vip_ctrl_busy, read, write,
        input  din_ready, data_in, width_in, height_in, interlaced_in, end_of_video_in,
               vip_ctrl_valid_in, dout_valid, dout_data, encoder_end_of_video,
               encoder_width, encoder_height, encoder_interlaced, encoder_vip_ctrl_send,
               stall_in, stall_out, overflow_err
    );

endinterface

// File: rtl/alt_vipvfr131_flow_ctrl_fifo.sv
// rtl/alt_vipvfr131_flow_ctrl_fifo.sv - synchronous non-fall-through FIFO with fill count
// Ports: clk, rst (async, active-high), push_i/pop_i requests, wdata_i/rdata_o,
// fill_o (current), fill_next_o (value after this edge), full_o, empty_o, push_ok_o, pop_ok_o.
module alt_vipvfr131_flow_ctrl_fifo
    import alt_vipvfr131_flow_ctrl_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [clog2(DEPTH+1)-1:0] fill_o,
    output logic [clog2(DEPTH+1)-1:0] fill_next_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             push_ok_o,
    output logic             pop_ok_o
);
    localparam int AW = clog2(DEPTH);
    localparam int FW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [FW-1:0]    fill_q;

    assign empty_o   = (fill_q == '0);
    assign full_o    = (fill_q == FW'(DEPTH));
    assign pop_ok_o  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a write on a full FIFO still lands.
    assign push_ok_o = push_i & (~full_o | pop_ok_o);
    assign fill_next_o = fill_q + FW'(push_ok_o) - FW'(pop_ok_o);
    assign fill_o    = fill_q;
    assign rdata_o   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push_ok_o) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_o)  rd_ptr_q <= rd_ptr_q + AW'(1);
            fill_q <= fill_next_o;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_o) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alt_vipvfr131_common_flow_control_buffered.sv
// rtl/alt_vipvfr131_common_flow_control_buffered.sv - VIP flow-control wrapper with output skid FIFO
// Ports: clk, rst (async, active-high), bus (slave modport of the signal bundle).
// Optional macro VIP_FLOW_CTRL_STATS_EN adds outputs frames_out[16] and stall_cycles[32].
module alt_vipvfr131_common_flow_control_buffered
    import alt_vipvfr131_flow_ctrl_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int OUT_FIFO_DEPTH   = 8,
    parameter int STALL_MARGIN     = 2,
    parameter int WIDTH_INIT       = WIDTH_INIT_DEF,
    parameter int HEIGHT_INIT      = HEIGHT_INIT_DEF
) (
    input  logic clk,
    input  logic rst,
    alt_vipvfr131_common_flow_control_buffered_if.slave bus
`ifdef VIP_FLOW_CTRL_STATS_EN
    ,
    output logic [15:0] frames_out,
    output logic [31:0] stall_cycles
`endif
);
    localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int EW = fifo_entry_width(DW);
    localparam int FW = clog2(OUT_FIFO_DEPTH + 1);
    localparam logic [FW-1:0] STALL_TH = FW'(OUT_FIFO_DEPTH - STALL_MARGIN);

    // Input side is pure pass-through.
    assign bus.din_ready         = ~bus.decoder_is_video | bus.read;
    assign bus.stall_in          = ~(bus.din_valid & bus.decoder_is_video);
    assign bus.data_in           = bus.din_data;
    assign bus.width_in          = bus.decoder_width;
    assign bus.height_in         = bus.decoder_height;
    assign bus.interlaced_in     = bus.decoder_interlaced;
    assign bus.end_of_video_in   = bus.decoder_end_of_video;
    assign bus.vip_ctrl_valid_in = bus.decoder_vip_ctrl_valid;

    logic [EW-1:0] rdata;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_next;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    alt_vipvfr131_flow_ctrl_fifo #(
        .WIDTH (EW),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.write),
        .pop_i       (bus.dout_ready),
        .wdata_i     ({bus.end_of_video_out, bus.data_out}),
        .rdata_o     (rdata),
        .fill_o      (fill),
        .fill_next_o (fill_next),
        .full_o      (full),
        .empty_o     (empty),
        .push_ok_o   (push_ok),
        .pop_ok_o    (pop_ok)
    );

    assign bus.dout_valid           = ~empty;
    assign bus.dout_data            = rdata[DW-1:0];
    assign bus.encoder_end_of_video = rdata[DW];

    logic [15:0] enc_width_q,  enc_width_d;
    logic [15:0] enc_height_q, enc_height_d;
    logic [3:0]  enc_intl_q,   enc_intl_d;
    logic        pending_q,    pending_d;
    logic        overflow_q,   overflow_d;
    logic        stall_q,      stall_d;
    logic        send;

    // Send only once all buffered video has left and nothing is entering,
    // so a control packet can never overtake video ahead of it.
    assign send = pending_q & ~bus.encoder_vip_ctrl_busy & empty & ~bus.write;

    always_comb begin
        enc_width_d  = enc_width_q;
        enc_height_d = enc_height_q;
        enc_intl_d   = enc_intl_q;
        pending_d    = pending_q;
        if (send) pending_d = 1'b0;
        // A new packet arriving with a send re-arms pending for a second send.
        if (bus.vip_ctrl_valid_out) begin
            enc_width_d  = bus.width_out;
            enc_height_d = bus.height_out;
            enc_intl_d   = bus.interlaced_out;
            pending_d    = 1'b1;
        end
        overflow_d = overflow_q | (bus.write & ~push_ok);
        stall_d    = (fill_next >= STALL_TH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_width_q  <= 16'(WIDTH_INIT);
            enc_height_q <= 16'(HEIGHT_INIT);
            enc_intl_q   <= '0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            enc_width_q  <= enc_width_d;
            enc_height_q <= enc_height_d;
            enc_intl_q   <= enc_intl_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.encoder_width         = enc_width_q;
    assign bus.encoder_height        = enc_height_q;
    assign bus.encoder_interlaced    = enc_intl_q;
    assign bus.encoder_vip_ctrl_send = send;
    assign bus.stall_out             = stall_q;
    assign bus.overflow_err          = overflow_q;

`ifdef VIP_FLOW_CTRL_STATS_EN
    logic [15:0] frames_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop_ok && rdata[DW]) frames_q <= frames_q + 16'd1;
            if (bus.dout_valid && !bus.dout_ready && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign frames_out   = frames_q;
    assign stall_cycles = stall_cnt_q;
`else
    logic unused_fill;
    assign unused_fill = ^{fill, full};
`endif

endmodule

// File: tb/tb_alt_vipvfr131_common_flow_control_buffered.sv
// tb/tb_alt_vipvfr131_common_flow_control_buffered.sv - directed self-checking bench for the flow-control wrapper
module tb_alt_vipvfr131_common_flow_control_buffered;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alt_vipvfr131_common_flow_control_buffered_if #(.DW(DW)) bus();

`ifdef VIP_FLOW_CTRL_STATS_EN
    logic [15:0] frames_out;
    logic [31:0] stall_cycles;
`endif

    alt_vipvfr131_common_flow_control_buffered dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef VIP_FLOW_CTRL_STATS_EN
        ,
        .frames_out   (frames_out),
        .stall_cycles (stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus.din_valid = 0; bus.din_data = '0; bus.decoder_width = '0; bus.decoder_height = '0;
        bus.decoder_interlaced = '0; bus.decoder_end_of_video = 0; bus.decoder_is_video = 0;
        bus.decoder_vip_ctrl_valid = 0; bus.data_out = '0; bus.width_out = '0; bus.height_out = '0;
        bus.interlaced_out = '0; bus.vip_ctrl_valid_out = 0; bus.end_of_video_out = 0;
        bus.dout_ready = 0; bus.encoder_vip_ctrl_busy = 0; bus.read = 0; bus.write = 0;
    endtask

    task automatic do_reset();
        init_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic eov);
        bus.write = 1; bus.data_out = d; bus.end_of_video_out = eov;
        step();
        bus.write = 0; bus.end_of_video_out = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.encoder_width !== 16'd640) begin bad++; $display("FAIL reset_width got=%0d exp=640", bus.encoder_width); end
        total++; if (bus.encoder_height !== 16'd480) begin bad++; $display("FAIL reset_height got=%0d exp=480", bus.encoder_height); end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", bus.dout_valid); end
        total++; if (bus.encoder_vip_ctrl_send !== 1'b0) begin bad++; $display("FAIL reset_send got=%b exp=0", bus.encoder_vip_ctrl_send); end
        total++; if (bus.stall_out !== 1'b0 || bus.overflow_err !== 1'b0) begin bad++; $display("FAIL reset_stall_ovf got=%b%b exp=00", bus.stall_out, bus.overflow_err); end
    endtask

    task automatic test_passthrough();
        bus.decoder_is_video = 1; bus.read = 0; bus.din_valid = 1; bus.din_data = 24'hABCDEF;
        bus.decoder_width = 16'd1234; #1;
        total++; if (bus.din_ready !== 1'b0 || bus.stall_in !== 1'b0) begin bad++; $display("FAIL pass_video_noread got=%b%b exp=00", bus.din_ready, bus.stall_in); end
        total++; if (bus.data_in !== 24'hABCDEF || bus.width_in !== 16'd1234) begin bad++; $display("FAIL pass_data got=%h/%0d exp=abcdef/1234", bus.data_in, bus.width_in); end
        bus.read = 1; #1;
        total++; if (bus.din_ready !== 1'b1) begin bad++; $display("FAIL pass_read got=%b exp=1", bus.din_ready); end
        bus.read = 0; bus.decoder_is_video = 0; #1;
        total++; if (bus.din_ready !== 1'b1 || bus.stall_in !== 1'b1) begin bad++; $display("FAIL pass_ctrl got=%b%b exp=11", bus.din_ready, bus.stall_in); end
        init_inputs();
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_beat(DW'(i), 1'b0);
            if (i == 4) begin
                total++; if (bus.stall_out !== 1'b0) begin bad++; $display("FAIL stall_after5 got=%b exp=0", bus.stall_out); end
            end
        end
        total++; if (bus.stall_out !== 1'b1) begin bad++; $display("FAIL stall_after6 got=%b exp=1", bus.stall_out); end
        push_beat(DW'(6), 1'b0);
        push_beat(DW'(7), 1'b0);
        total++; if (bus.overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_at8 got=%b exp=0", bus.overflow_err); end
        push_beat(DW'(99), 1'b0);
        total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_at9 got=%b exp=1", bus.overflow_err); end
        bus.dout_ready = 1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (bus.dout_valid !== 1'b1 || bus.dout_data !== DW'(k)) begin
                bad++; $display("FAIL drain_full beat%0d got=%b/%0d exp=1/%0d", k, bus.dout_valid, bus.dout_data, k);
            end
            step();
        end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", bus.dout_valid); end
        total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow_err); end
        bus.dout_ready = 0;
    endtask

    task automatic test_full_write_pop();
        do_reset();
        for (int i = 0; i < 8; i++) push_beat(DW'(10 + i), 1'b0);
        bus.write = 1; bus.data_out = DW'(18); bus.dout_ready = 1; #1;
        total++; if (bus.dout_data !== DW'(10)) begin bad++; $display("FAIL wp_head got=%0d exp=10", bus.dout_data); end
        step();
        bus.write = 0; bus.dout_ready = 0; #1;
        total++; if (bus.overflow_err !== 1'b0) begin bad++; $display("FAIL wp_ovf got=%b exp=0", bus.overflow_err); end
        total++; if (bus.stall_out !== 1'b1) begin bad++; $display("FAIL wp_stall got=%b exp=1", bus.stall_out); end
        bus.dout_ready = 1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (bus.dout_valid !== 1'b1 || bus.dout_data !== DW'(11 + k)) begin
                bad++; $display("FAIL wp_order beat%0d got=%b/%0d exp=1/%0d", k, bus.dout_valid, bus.dout_data, 11 + k);
            end
            step();
        end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL wp_empty got=%b exp=0", bus.dout_valid); end
        bus.dout_ready = 0;
    endtask

    task automatic test_ctrl_ordering();
        int sends;
        int pops;
        do_reset();
        push_beat(DW'(1), 1'b0);
        push_beat(DW'(2), 1'b0);
        push_beat(DW'(3), 1'b1);
        bus.vip_ctrl_valid_out = 1; bus.width_out = 16'd1920; bus.height_out = 16'd1080;
        step();
        bus.vip_ctrl_valid_out = 0;
        total++; if (bus.encoder_width !== 16'd1920) begin bad++; $display("FAIL ord_width got=%0d exp=1920", bus.encoder_width); end
        total++; if (bus.encoder_vip_ctrl_send !== 1'b0) begin bad++; $display("FAIL ord_held got=%b exp=0", bus.encoder_vip_ctrl_send); end
        sends = 0; pops = 0;
        bus.dout_ready = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.encoder_vip_ctrl_send === 1'b1) begin
                if (sends == 0) begin
                    total++;
                    if (pops != 3 || bus.dout_valid !== 1'b0) begin
                        bad++; $display("FAIL ord_overtake pops=%0d valid=%b exp=3/0", pops, bus.dout_valid);
                    end
                end
                sends++;
            end
            if (bus.dout_valid === 1'b1) pops++;
            step();
        end
        bus.dout_ready = 0;
        total++; if (sends != 1) begin bad++; $display("FAIL ord_sends got=%0d exp=1", sends); end
        total++; if (pops != 3) begin bad++; $display("FAIL ord_pops got=%0d exp=3", pops); end
        total++; if (bus.encoder_height !== 16'd1080) begin bad++; $display("FAIL ord_height got=%0d exp=1080", bus.encoder_height); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.vip_ctrl_valid_out = 1; bus.width_out = 16'd1280; bus.height_out = 16'd720;
        step();
        bus.vip_ctrl_valid_out = 0; #1;
        total++; if (bus.encoder_vip_ctrl_send !== 1'b1 || bus.encoder_width !== 16'd1280) begin
            bad++; $display("FAIL b2b_first got=%b/%0d exp=1/1280", bus.encoder_vip_ctrl_send, bus.encoder_width); end
        bus.vip_ctrl_valid_out = 1; bus.width_out = 16'd720; bus.height_out = 16'd576;
        step();
        bus.vip_ctrl_valid_out = 0; #1;
        total++; if (bus.encoder_vip_ctrl_send !== 1'b1 || bus.encoder_width !== 16'd720 || bus.encoder_height !== 16'd576) begin
            bad++; $display("FAIL b2b_second got=%b/%0dx%0d exp=1/720x576", bus.encoder_vip_ctrl_send, bus.encoder_width, bus.encoder_height); end
        step();
        total++; if (bus.encoder_vip_ctrl_send !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b exp=0", bus.encoder_vip_ctrl_send); end
        // busy holds the send off
        bus.encoder_vip_ctrl_busy = 1; bus.vip_ctrl_valid_out = 1; bus.width_out = 16'd100;
        step();
        bus.vip_ctrl_valid_out = 0;
        step();
        total++; if (bus.encoder_vip_ctrl_send !== 1'b0) begin bad++; $display("FAIL busy_hold got=%b exp=0", bus.encoder_vip_ctrl_send); end
        bus.encoder_vip_ctrl_busy = 0; #1;
        total++; if (bus.encoder_vip_ctrl_send !== 1'b1) begin bad++; $display("FAIL busy_release got=%b exp=1", bus.encoder_vip_ctrl_send); end
        step();
        // a push in the same cycle blocks the send
        bus.vip_ctrl_valid_out = 1; bus.width_out = 16'd200;
        step();
        bus.vip_ctrl_valid_out = 0; bus.write = 1; bus.data_out = DW'(5); #1;
        total++; if (bus.encoder_vip_ctrl_send !== 1'b0) begin bad++; $display("FAIL push_blocks got=%b exp=0", bus.encoder_vip_ctrl_send); end
        step();
        bus.write = 0; bus.dout_ready = 1;
        step();
        total++; if (bus.encoder_vip_ctrl_send !== 1'b1) begin bad++; $display("FAIL push_after got=%b exp=1", bus.encoder_vip_ctrl_send); end
        bus.dout_ready = 0;
        step();
    endtask

    task automatic test_reset_midframe();
        push_beat(DW'(7), 1'b0);
        bus.vip_ctrl_valid_out = 1; bus.width_out = 16'd333;
        step();
        bus.vip_ctrl_valid_out = 0;
        do_reset();
        total++; if (bus.dout_valid !== 1'b0 || bus.encoder_vip_ctrl_send !== 1'b0 || bus.encoder_width !== 16'd640) begin
            bad++; $display("FAIL midreset got=%b/%b/%0d exp=0/0/640", bus.dout_valid, bus.encoder_vip_ctrl_send, bus.encoder_width); end
    endtask

`ifdef VIP_FLOW_CTRL_STATS_EN
    task automatic test_stats();
        do_reset();
        total++; if (frames_out !== 16'd0 || stall_cycles !== 32'd0) begin bad++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", frames_out, stall_cycles); end
        for (int f = 0; f < 3; f++) begin
            push_beat(DW'(f), 1'b0);
            push_beat(DW'(f), 1'b1);
        end
        total++; if (stall_cycles !== 32'd5) begin bad++; $display("FAIL stats_stall got=%0d exp=5", stall_cycles); end
        bus.dout_ready = 1;
        for (int k = 0; k < 8; k++) step();
        total++; if (frames_out !== 16'd3) begin bad++; $display("FAIL stats_frames got=%0d exp=3", frames_out); end
        do_reset();
        bus.dout_ready = 1; bus.write = 1; bus.end_of_video_out = 1;
        for (int k = 0; k < 65535; k++) step();
        bus.write = 0;
        step();
        total++; if (frames_out !== 16'hFFFF) begin bad++; $display("FAIL stats_preload got=%0d exp=65535", frames_out); end
        push_beat(DW'(1), 1'b1);
        step();
        total++; if (frames_out !== 16'd0) begin bad++; $display("FAIL stats_wrap got=%0d exp=0", frames_out); end
        bus.dout_ready = 0;
    endtask
`endif

    initial begin
        init_inputs();
        rst = 1'b1;
        test_reset();
        test_passthrough();
        test_fill_overflow();
        test_full_write_pop();
        test_ctrl_ordering();
        test_back_to_back();
        test_reset_midframe();
`ifdef VIP_FLOW_CTRL_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
